// File: rtl/ap_ctrl_seq_pkg.sv
// Shared types and defaults for the ap_ctrl transaction sequencer.
package ap_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  localparam int unsigned CNT_W_DEF           = 32;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;
  localparam int unsigned LAT_W_DEF           = 32;

  // Width able to hold 0..max_out inclusive.
  function automatic int unsigned outst_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/ap_seq_ts_fifo.sv
// Small synchronous FIFO holding start timestamps; first-word fall-through read.
module ap_seq_ts_fifo
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Runs a programmed number of back-to-back ap_ctrl transactions with an in-flight cap.
// Define AP_CTRL_SEQ_LATENCY_EN to build the timestamp counter/FIFO and live latency reports.
module ap_ctrl_sequencer
  import ap_ctrl_seq_pkg::*;
#(
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned LAT_W           = LAT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             done_hold,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic             err,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_value
);

  localparam int unsigned OW = outst_width(MAX_OUTSTANDING);

  seq_state_e       state;
  seq_state_e       state_nx;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] target_nx;
  logic [CNT_W-1:0] issued_nx;
  logic [CNT_W-1:0] done_nx;
  logic [OW-1:0]    outst_q;
  logic [OW-1:0]    outst_nx;
  logic             err_nx;
  logic             ap_start_nx;
  logic             start_acc;
  logic             done_acc;
  logic             done_ok;
  logic             run_go;

  assign ap_continue = !done_hold;
  assign start_acc   = ap_start & ap_ready;
  assign done_acc    = ap_done & ap_continue;
  // A done with nothing in flight is a protocol error and moves no counter.
  assign done_ok     = done_acc & (outst_q != '0);
  assign run_go      = (state == IDLE) & cfg_start;

  // Next-state, counter and start-request logic.
  always_comb begin
    state_nx  = state;
    target_nx = target_q;
    issued_nx = issued_cnt;
    done_nx   = done_cnt;
    outst_nx  = outst_q;
    err_nx    = err;

    if (run_go) begin
      target_nx = cfg_count;
      issued_nx = '0;
      done_nx   = '0;
      outst_nx  = '0;
      err_nx    = 1'b0;
    end else begin
      if (start_acc) issued_nx = issued_cnt + CNT_W'(1);
      if (done_ok)   done_nx   = done_cnt + CNT_W'(1);
      case ({start_acc, done_ok})
        2'b10:   outst_nx = outst_q + OW'(1);
        2'b01:   outst_nx = outst_q - OW'(1);
        default: outst_nx = outst_q;
      endcase
    end

    if ((done_acc && (outst_q == '0)) || (ap_ready && !ap_start)) err_nx = 1'b1;

    case (state)
      IDLE:    if (cfg_start) state_nx = (cfg_count == '0) ? FIN : ISSUE;
      ISSUE:   if (issued_nx == target_q) state_nx = (done_nx == target_q) ? FIN : DRAIN;
      DRAIN:   if (done_nx == target_q) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    ap_start_nx = (state_nx == ISSUE) && (issued_nx < target_nx) &&
                  (outst_nx < OW'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      target_q   <= '0;
      issued_cnt <= '0;
      done_cnt   <= '0;
      outst_q    <= '0;
      err        <= 1'b0;
      ap_start   <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state      <= state_nx;
      target_q   <= target_nx;
      issued_cnt <= issued_nx;
      done_cnt   <= done_nx;
      outst_q    <= outst_nx;
      err        <= err_nx;
      ap_start   <= ap_start_nx;
      busy       <= (state_nx != IDLE);
      finish     <= (state_nx == FIN);
    end
  end

`ifdef AP_CTRL_SEQ_LATENCY_EN
  logic [LAT_W-1:0] ts_q;
  logic [LAT_W-1:0] ts_head;
  logic             fifo_empty;
  logic             fifo_full;

  ap_seq_ts_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LAT_W)
  ) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .push  (start_acc),
    .pop   (done_ok),
    .wdata (ts_q),
    .rdata (ts_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Completions are in order, so the FIFO head is the start time of this done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q      <= '0;
      lat_valid <= 1'b0;
      lat_value <= '0;
    end else begin
      assert (!(start_acc && fifo_full));
      ts_q      <= ts_q + LAT_W'(1);
      lat_valid <= done_ok & ~fifo_empty;
      if (done_ok) lat_value <= ts_q - ts_head;
    end
  end
`else
  assign lat_valid = 1'b0;
  assign lat_value = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Randomized self-checking bench for ap_ctrl_sequencer with a transaction-level reference model.
module tb_ap_ctrl_sequencer;

  localparam int unsigned MAX = 4;
`ifdef AP_CTRL_SEQ_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_count = 32'd0;
  logic        done_hold = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_start, ap_continue, busy, finish, err, lat_valid;
  logic [31:0] issued_cnt, done_cnt, lat_value;

  ap_ctrl_sequencer #(
    .CNT_W           (32),
    .MAX_OUTSTANDING (MAX),
    .LAT_W           (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_start   (cfg_start),
    .cfg_count   (cfg_count),
    .done_hold   (done_hold),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .busy        (busy),
    .finish      (finish),
    .issued_cnt  (issued_cnt),
    .done_cnt    (done_cnt),
    .err         (err),
    .lat_valid   (lat_valid),
    .lat_value   (lat_value)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a run is "running" until every done arrives, then one finish cycle.
  bit          m_run, m_fin, m_start, m_err, m_lv;
  logic [31:0] m_tgt, m_iss, m_dn, m_lat, m_ts;
  logic [31:0] m_q[$];

  // Kernel stand-in: in-order completion queue of due cycles.
  logic [31:0] kq[$];
  logic [31:0] kc = 32'd0;
  int unsigned ready_pct = 100, lat_min = 1, lat_max = 1, hold_pct = 0;
  int          hold_left = 0;
  bit          withhold = 1'b0, spur_ready = 1'b0, noise = 1'b0, force_done = 1'b0;
  bit          pend_go = 1'b0;
  logic [31:0] pend_cnt = 32'd0;

  int          obs_start_n, obs_start_run, obs_start_max, obs_lat_n, obs_fin_n;
  logic [31:0] obs_lat_sum;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_fin = 0; m_start = 0; m_err = 0; m_lv = 0;
    m_tgt = 0; m_iss = 0; m_dn = 0; m_lat = 0; m_ts = 0;
    m_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs just driven.
  task automatic model_update();
    bit s_acc, d_acc, d_ok, err_now;
    if (reset) begin
      model_clear();
      return;
    end
    s_acc   = m_start && ap_ready;
    d_acc   = ap_done && !done_hold;
    d_ok    = d_acc && (m_q.size() != 0);
    err_now = (d_acc && (m_q.size() == 0)) || (ap_ready && !m_start);
    m_lv    = 0;
    if (!m_run && !m_fin && cfg_start) begin
      m_tgt = cfg_count; m_iss = 0; m_dn = 0; m_q.delete();
      m_err = err_now;
      m_run = (cfg_count != 0);
      m_fin = (cfg_count == 0);
    end else begin
      if (d_ok) begin
        m_dn++;
        m_lat = m_ts - m_q.pop_front();
        m_lv  = 1;
      end
      if (s_acc) begin
        m_iss++;
        m_q.push_back(m_ts);
      end
      m_err = m_err | err_now;
      if (m_fin) m_fin = 0;
      else if (m_run && (m_dn == m_tgt)) begin
        m_run = 0;
        m_fin = 1;
      end
    end
    m_start = m_run && (m_iss < m_tgt) && (m_q.size() < MAX);
    m_ts++;
  endtask

  // One cycle: compare at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    bit cand;
    @(negedge clock);
    check_eq("ap_start", 32'(ap_start), 32'(m_start));
    check_eq("busy", 32'(busy), 32'(m_run | m_fin));
    check_eq("finish", 32'(finish), 32'(m_fin));
    check_eq("issued_cnt", issued_cnt, m_iss);
    check_eq("done_cnt", done_cnt, m_dn);
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("lat_valid", 32'(lat_valid), 32'(LAT_EN & m_lv));
    check_eq("lat_value", lat_value, LAT_EN ? m_lat : 32'd0);
    check_eq("ap_continue", 32'(ap_continue), 32'(!done_hold));

    if (ap_start) begin
      obs_start_n++;
      obs_start_run++;
      if (obs_start_run > obs_start_max) obs_start_max = obs_start_run;
    end else obs_start_run = 0;
    if (lat_valid) begin
      obs_lat_n++;
      obs_lat_sum = obs_lat_sum + lat_value;
    end
    if (finish) obs_fin_n++;

    cfg_start = pend_go;
    cfg_count = pend_go ? pend_cnt : $urandom;
    if (!pend_go && noise && m_run && ($urandom_range(19, 0) == 0)) cfg_start = 1'b1;
    pend_go = 1'b0;

    ap_ready = ap_start && ($urandom_range(99, 0) < ready_pct);
    if (spur_ready && !ap_start && ($urandom_range(99, 0) < 3)) ap_ready = 1'b1;

    cand = (kq.size() != 0) && !withhold && (kq[0] <= kc);
    ap_done = cand || force_done;
    force_done = 1'b0;
    if (hold_left > 0 && ap_done) begin
      done_hold = 1'b1;
      hold_left--;
    end else done_hold = ($urandom_range(99, 0) < hold_pct);

    if (cand && !done_hold) void'(kq.pop_front());
    if (ap_start && ap_ready) kq.push_back(kc + $urandom_range(lat_max, lat_min));
    kc++;
    model_update();
  endtask

  task automatic start_run(input logic [31:0] cnt);
    obs_start_n = 0; obs_start_run = 0; obs_start_max = 0;
    obs_lat_n = 0; obs_fin_n = 0; obs_lat_sum = 0;
    pend_go  = 1'b1;
    pend_cnt = cnt;
    step();
  endtask

  task automatic run_to_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic set_kernel(input int unsigned rp, input int unsigned lmin,
                            input int unsigned lmax, input int unsigned hp);
    ready_pct = rp; lat_min = lmin; lat_max = lmax; hold_pct = hp;
  endtask

  initial begin
    model_clear();
    obs_lat_sum = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_eq("rst_ap_start", 32'(ap_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_issued", issued_cnt, 32'd0);

    // Three back-to-back starts, fixed latency 10.
    set_kernel(100, 10, 10, 0);
    start_run(32'd3);
    run_to_idle(100, "t1_timeout");
    check_eq("t1_start_burst", 32'(obs_start_max), 32'd3);
    check_eq("t1_start_total", 32'(obs_start_n), 32'd3);
    check_eq("t1_lat_pulses", 32'(obs_lat_n), LAT_EN ? 32'd3 : 32'd0);
    check_eq("t1_lat_sum", obs_lat_sum, LAT_EN ? 32'd30 : 32'd0);
    check_eq("t1_finish_pulses", 32'(obs_fin_n), 32'd1);
    check_eq("t1_done_cnt", done_cnt, 32'd3);

    // Outstanding cap with completions withheld, then a single release.
    set_kernel(100, 3, 3, 0);
    withhold = 1'b1;
    start_run(32'd6);
    repeat (12) step();
    check_eq("t2_issued_capped", issued_cnt, 32'd4);
    check_eq("t2_start_low", 32'(ap_start), 32'd0);
    withhold = 1'b0;
    step();
    withhold = 1'b1;
    step();
    check_eq("t2_start_reassert", 32'(ap_start), 32'd1);
    step();
    check_eq("t2_issued_after", issued_cnt, 32'd5);
    withhold = 1'b0;
    run_to_idle(200, "t2_timeout");

    // Start and done accepted together with two in flight.
    set_kernel(100, 2, 2, 0);
    start_run(32'd4);
    repeat (4) step();
    check_eq("t3_issued", issued_cnt, 32'd3);
    check_eq("t3_done", done_cnt, 32'd1);
    run_to_idle(100, "t3_timeout");

    // Downstream holds a pending done for five cycles.
    set_kernel(100, 3, 3, 0);
    hold_left = 5;
    start_run(32'd1);
    run_to_idle(100, "t4_timeout");
    check_eq("t4_lat_sum", obs_lat_sum, LAT_EN ? 32'd8 : 32'd0);
    check_eq("t4_done_cnt", done_cnt, 32'd1);

    // Spurious done while idle.
    force_done = 1'b1;
    step();
    step();
    check_eq("spur_err", 32'(err), 32'd1);
    check_eq("spur_done_cnt", done_cnt, 32'd1);
    check_eq("spur_issued_cnt", issued_cnt, 32'd1);

    // Empty run: finish only.
    start_run(32'd0);
    run_to_idle(10, "t5_timeout");
    check_eq("t5_finish_pulses", 32'(obs_fin_n), 32'd1);
    check_eq("t5_no_start", 32'(obs_start_n), 32'd0);

    // Reset mid-run with two outstanding.
    set_kernel(100, 20, 20, 0);
    start_run(32'd4);
    repeat (3) step();
    check_eq("t6_issued_pre", issued_cnt, 32'd2);
    #1 reset = 1'b1;
    model_clear();
    kq.delete();
    #1;
    check_eq("t6_rst_ap_start", 32'(ap_start), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_finish", 32'(finish), 32'd0);
    check_eq("t6_rst_issued", issued_cnt, 32'd0);
    check_eq("t6_rst_done", done_cnt, 32'd0);
    check_eq("t6_rst_err", 32'(err), 32'd0);
    check_eq("t6_rst_lat_valid", 32'(lat_valid), 32'd0);
    check_eq("t6_rst_lat_value", lat_value, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    check_eq("t6_no_finish", 32'(obs_fin_n), 32'd0);
    set_kernel(100, 7, 7, 0);
    start_run(32'd1);
    run_to_idle(100, "t6_timeout");
    check_eq("t6_lat_sum", obs_lat_sum, LAT_EN ? 32'd7 : 32'd0);
    check_eq("t6_done_cnt", done_cnt, 32'd1);

    // Randomized runs against the model.
    noise = 1'b1;
    for (int r = 0; r < 40; r++) begin
      set_kernel($urandom_range(100, 40), 1, 1, $urandom_range(30, 0));
      lat_min = $urandom_range(4, 1);
      lat_max = lat_min + $urandom_range(10, 0);
      spur_ready = ($urandom_range(3, 0) == 0);
      start_run($urandom_range(12, 0));
      run_to_idle(3000, "rand_timeout");
      repeat ($urandom_range(3, 0)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
